// File: rtl/bcd_counter.sv
// bcd_counter: NUM_DIGITS-decade BCD up/down counter with synchronous
// parallel load (nibbles above 9 are replaced by 0 and flagged on load_err),
// count enable / carry-in, a combinational cascade carry/borrow output and
// a sticky wrap flag.
//
// Optional build macro: BCD_COUNTER_SAT_EN
//   undefined (default): a count step at the terminal value wraps around
//                        (9..9 -> 0..0 up, 0..0 -> 9..9 down).
//   defined:             a count step at the terminal value leaves digits
//                        unchanged; wrapped then marks a saturation hit.
//
// Cascade: c_in of an upper instance is driven by c_out of the lower one.
// c_out is high in the very cycle the lower instance is about to wrap, so
// both instances update on the same clock edge. Both instances should
// share up_dn.
//
// No FSM and no valid/ready handshake live here. Observable state is
// digits, wrapped and load_err, all registered.
module bcd_counter #(
    parameter int                      NUM_DIGITS = 4,
    parameter logic [4*NUM_DIGITS-1:0] RST_VAL    = '0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      c_in,
    input  logic                      up_dn,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_val,
    input  logic                      clr_wrap,
    output logic [4*NUM_DIGITS-1:0]   digits,
    output logic                      c_out,
    output logic                      wrapped,
    output logic                      load_err
);

    localparam int W = 4 * NUM_DIGITS;

    // Value every digit must hold for the digit above it to step:
    // 9 when counting up, 0 when counting down.
    logic [3:0]            term_digit;
    // step_en[i] is high when digit i steps on a count cycle;
    // step_en[NUM_DIGITS] is high when the whole count sits at the terminal value.
    logic [NUM_DIGITS:0]   step_en;
    logic                  at_term;
    logic [W-1:0]          count_val;
    logic [W-1:0]          load_clean;
    logic                  load_bad;
    logic                  wrap_evt;
    logic [W-1:0]          digits_next;
    logic                  wrapped_next;
    logic                  load_err_next;

    // Sanitise the load value: any nibble above 9 becomes 0 and is flagged.
    always_comb begin
        load_clean = '0;
        load_bad   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) begin
                load_bad = 1'b1;
            end else begin
                load_clean[4*i +: 4] = load_val[4*i +: 4];
            end
        end
    end

    // Ripple enable chain: a digit steps when every lower digit is terminal.
    always_comb begin
        term_digit = up_dn ? 4'd9 : 4'd0;
        step_en    = '0;
        step_en[0] = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            step_en[i+1] = step_en[i] & (digits[4*i +: 4] == term_digit);
        end
        at_term = step_en[NUM_DIGITS];
    end

    // Candidate value for a count cycle: each enabled digit steps by one
    // with decade roll-over, the rest hold.
    always_comb begin
        count_val = digits;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (step_en[i]) begin
                if (up_dn) begin
                    count_val[4*i +: 4] = (digits[4*i +: 4] == 4'd9) ? 4'd0
                                                                     : digits[4*i +: 4] + 4'd1;
                end else begin
                    count_val[4*i +: 4] = (digits[4*i +: 4] == 4'd0) ? 4'd9
                                                                     : digits[4*i +: 4] - 4'd1;
                end
            end
        end
`ifdef BCD_COUNTER_SAT_EN
        // Saturating build: a step at the terminal value changes nothing.
        if (at_term) begin
            count_val = digits;
        end
`endif
    end

    // Cascade output: zero latency so the next instance steps on the same edge.
    assign c_out    = reset_n & ~load & c_in & at_term;

    // A wrap (or saturation hit) is a count cycle taken at the terminal value.
    assign wrap_evt = ~load & c_in & at_term;

    // Next-state selection: load beats count beats hold; a wrap beats clr_wrap.
    always_comb begin
        digits_next   = digits;
        wrapped_next  = wrapped;
        load_err_next = 1'b0;
        if (load) begin
            digits_next   = load_clean;
            load_err_next = load_bad;
        end else if (c_in) begin
            digits_next   = count_val;
        end
        if (wrap_evt) begin
            wrapped_next = 1'b1;
        end else if (clr_wrap) begin
            wrapped_next = 1'b0;
        end
    end

    // State register with synchronous active-low reset taking top priority.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            digits   <= RST_VAL;
            wrapped  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            digits   <= digits_next;
            wrapped  <= wrapped_next;
            load_err <= load_err_next;
        end
    end

endmodule
